// File: rtl/adder_64.sv
// Registered ripple-carry adder, {carryOut, sum} = a + b + carryIn.
// Built from 1-bit cells up through 4-, 16- and 64-bit ripple groups.

module adder_64_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module adder_64_g4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        adder_64_fa u_fa (
            .a_i(a_i[i]),
            .b_i(b_i[i]),
            .c_i(c[i]),
            .s_o(s_o[i]),
            .c_o(c[i+1])
        );
    end

    assign c_o = c[4];
endmodule

module adder_64_g16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);
    logic [4:0] c;

    assign c[0] = c_i;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        adder_64_g4 u_g4 (
            .a_i(a_i[4*k +: 4]),
            .b_i(b_i[4*k +: 4]),
            .c_i(c[k]),
            .s_o(s_o[4*k +: 4]),
            .c_o(c[k+1])
        );
    end

    assign c_o = c[4];
endmodule

module adder_64_g64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        c_i,
    output logic [63:0] s_o,
    output logic        c_o
);
    logic [4:0] c;

    assign c[0] = c_i;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        adder_64_g16 u_g16 (
            .a_i(a_i[16*k +: 16]),
            .b_i(b_i[16*k +: 16]),
            .c_i(c[k]),
            .s_o(s_o[16*k +: 16]),
            .c_o(c[k+1])
        );
    end

    assign c_o = c[4];
endmodule

module adder_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             carryIn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    if (WIDTH == 4) begin : g_w4
        adder_64_g4 u_add (
            .a_i(a),
            .b_i(b),
            .c_i(carryIn),
            .s_o(sum_d),
            .c_o(carry_d)
        );
    end else if (WIDTH == 16) begin : g_w16
        adder_64_g16 u_add (
            .a_i(a),
            .b_i(b),
            .c_i(carryIn),
            .s_o(sum_d),
            .c_o(carry_d)
        );
    end else if (WIDTH == 64) begin : g_w64
        adder_64_g64 u_add (
            .a_i(a),
            .b_i(b),
            .c_i(carryIn),
            .s_o(sum_d),
            .c_o(carry_d)
        );
    end else begin : g_bad
        $error("adder_64: WIDTH must be 4, 16 or 64");
        assign sum_d   = '0;
        assign carry_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum      = sum_q;
    assign carryOut = carry_q;
endmodule

// File: tb/tb_adder_64.sv
// Bench for adder_64: all three widths side by side, directed and random
// vectors checked against plain-arithmetic a + b + carryIn.

module tb_adder_64;
    logic        clk = 1'b0;
    logic        rstN;
    logic        cin;
    logic [3:0]  a4, b4, s4;
    logic [15:0] a16, b16, s16;
    logic [63:0] a64, b64, s64;
    logic        c4, c16, c64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_64 #(.WIDTH(4)) u_d4 (
        .clk(clk), .rstN(rstN), .carryIn(cin),
        .a(a4), .b(b4), .sum(s4), .carryOut(c4)
    );

    adder_64 #(.WIDTH(16)) u_d16 (
        .clk(clk), .rstN(rstN), .carryIn(cin),
        .a(a16), .b(b16), .sum(s16), .carryOut(c16)
    );

    adder_64 #(.WIDTH(64)) u_d64 (
        .clk(clk), .rstN(rstN), .carryIn(cin),
        .a(a64), .b(b64), .sum(s64), .carryOut(c64)
    );

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Carry lands in bit WIDTH of the 65-bit result since operands are < 2^WIDTH.
    function automatic logic [64:0] model(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input logic ci, input logic rn);
        logic [64:0] r;
        r = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        return rn ? r : 65'd0;
    endfunction

    task automatic step(input logic [3:0] xa4, input logic [3:0] xb4,
                        input logic [15:0] xa16, input logic [15:0] xb16,
                        input logic [63:0] xa64, input logic [63:0] xb64,
                        input logic ci, input logic rn, input string tag);
        logic [64:0] e4, e16, e64;
        a4 = xa4;   b4 = xb4;
        a16 = xa16; b16 = xb16;
        a64 = xa64; b64 = xb64;
        cin = ci;   rstN = rn;
        e4  = model({60'd0, xa4}, {60'd0, xb4}, ci, rn);
        e16 = model({48'd0, xa16}, {48'd0, xb16}, ci, rn);
        e64 = model(xa64, xb64, ci, rn);
        @(posedge clk);
        #1;
        chk({tag, "_w4"},  {60'd0, c4, s4}, e4);
        chk({tag, "_w16"}, {48'd0, c16, s16}, e16);
        chk({tag, "_w64"}, {c64, s64}, e64);
    endtask

    initial begin
        logic [63:0] r64a, r64b;
        logic        rn;

        step('1, '1, '1, '1, '1, '1, 1'b1, 1'b0, "rst_hold1");
        step('1, '1, '1, '1, '1, '1, 1'b1, 1'b0, "rst_hold2");
        step('1, '1, '1, '1, '1, '1, 1'b1, 1'b1, "rst_release");

        step(4'b0011, 4'b0110, 16'h1944, 16'h2246,
             64'h1944_2246_2246_2246, 64'h1950_1103_1844_A711,
             1'b0, 1'b1, "plan_vec");
        chk("plan_w4_sum", {61'd0, s4}, 65'h9);
        chk("plan_w16_sum", {49'd0, s16}, 65'h3B8A);
        chk("plan_w64_sum", {1'b0, s64}, {1'b0, 64'h3294_3349_3A8A_C957});

        step('1, '0, '1, '0, '1, '0, 1'b1, 1'b1, "chain_ones_zero");
        chk("chain_w64_lit", {c64, s64}, {1'b1, 64'd0});
        step('1, '1, '1, '1, '1, '1, 1'b1, 1'b1, "chain_ones_ones");
        chk("chain2_w64_lit", {c64, s64}, {1'b1, {64{1'b1}}});
        step(4'h8, 4'h8, 16'h8000, 16'h8000, 64'h8000_0000_0000_0000,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, "msb_carry");
        step('0, '0, '0, '0, '0, '0, 1'b1, 1'b1, "cin_only");

        for (int i = 0; i < 1200; i++) begin
            r64a = {$urandom, $urandom};
            r64b = {$urandom, $urandom};
            rn = !(i == 400 || i == 777);
            step(r64a[3:0], r64b[3:0], r64a[19:4], r64b[19:4],
                 r64a, r64b, 1'($urandom_range(0, 1)), rn,
                 rn ? "rand" : "rand_rstpulse");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
